pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/data_path_muxs_pkg.sv | 12 +
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 tb/tb_pc_fetch_unit.sv | 135 +++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the datapath blocks.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selects and the fetch-unit FSM states.
package data_path_muxs_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {SEL_NPC, SEL_BRANCH, SEL_JUMP, SEL_JR} pc_mux_input_selection;
  typedef enum logic [1:0] {RUN, PEND, HALTED} pc_fetch_state_t;

  // Clears the byte offset so the PC always stays word aligned.
  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(3);
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Signal bundle for the fetch unit, with views for the unit and its driver.
interface pc_fetch_unit_if;
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;

  logic                  CLK, nRST;
  logic                  enable_pc, ihit, halt;
  pc_mux_input_selection PCSrc;
  word_t                 branch_target_EX_MEM, jr_target, npc_IF_ID;
  logic [25:0]           jaddr_IF_ID;
  word_t                 imemaddr, pc_IF, npc_IF;
  logic                  imemREN, halted;

  modport pc_fetch_unit (
    input  CLK, nRST, enable_pc, ihit, halt, PCSrc,
           branch_target_EX_MEM, jr_target, npc_IF_ID, jaddr_IF_ID,
    output imemaddr, pc_IF, npc_IF, imemREN, halted
  );
  modport tb (
    output CLK, nRST, enable_pc, ihit, halt, PCSrc,
           branch_target_EX_MEM, jr_target, npc_IF_ID, jaddr_IF_ID,
    input  imemaddr, pc_IF, npc_IF, imemREN, halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: holds redirects until the fetch can advance.
module pc_fetch_unit
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  enable_pc,
  input  pc_mux_input_selection PCSrc,
  input  logic                  ihit,
  input  logic                  halt,
  input  word_t                 branch_target_EX_MEM,
  input  word_t                 jr_target,
  input  logic [25:0]           jaddr_IF_ID,
  input  word_t                 npc_IF_ID,
  output word_t                 imemaddr,
  output logic                  imemREN,
  output word_t                 pc_IF,
  output word_t                 npc_IF,
  output logic                  halted
);
  pc_fetch_state_t       state, state_nxt;
  word_t                 pc, pc_nxt;
  word_t                 pend_addr, pend_addr_nxt;
  pc_mux_input_selection pend_src, pend_src_nxt;
  word_t                 jump_tgt, mux_tgt;
  logic                  adv;

  assign adv      = enable_pc && ihit;
  // Masking keeps the region bits of npc_IF_ID and drops the rest.
  assign jump_tgt = (npc_IF_ID & 32'hF000_0000) | {4'b0, jaddr_IF_ID, 2'b00};

  always_comb begin
    mux_tgt = pc + 32'd4;
    case (PCSrc)
      SEL_BRANCH: mux_tgt = branch_target_EX_MEM;
      SEL_JUMP:   mux_tgt = jump_tgt;
      SEL_JR:     mux_tgt = jr_target;
      default:    mux_tgt = pc + 32'd4;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      pc        <= word_align(PC_INIT);
      pend_addr <= '0;
      pend_src  <= SEL_NPC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      pend_addr <= pend_addr_nxt;
      pend_src  <= pend_src_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pend_addr_nxt = pend_addr;
    pend_src_nxt  = pend_src;
    if (halt) begin
      state_nxt     = HALTED;
      pend_addr_nxt = '0;
      pend_src_nxt  = SEL_NPC;
    end else begin
      case (state)
        RUN: begin
          if (adv) begin
            pc_nxt = word_align(mux_tgt);
          end else if (PCSrc != SEL_NPC) begin
            pend_addr_nxt = word_align(mux_tgt);
            pend_src_nxt  = PCSrc;
            state_nxt     = PEND;
          end
        end
        PEND: begin
          if (adv) begin
            // A branch arriving now is older than whatever is pending.
            pc_nxt        = (PCSrc == SEL_BRANCH) ? word_align(branch_target_EX_MEM) : pend_addr;
            pend_addr_nxt = '0;
            pend_src_nxt  = SEL_NPC;
            state_nxt     = RUN;
          end else if (PCSrc == SEL_BRANCH ||
                       (PCSrc != SEL_NPC && pend_src != SEL_BRANCH)) begin
            pend_addr_nxt = word_align(mux_tgt);
            pend_src_nxt  = PCSrc;
          end
        end
        HALTED:  state_nxt = HALTED;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    imemREN = (state != HALTED);
    halted  = (state == HALTED);
  end

  assign imemaddr = pc;
  assign pc_IF    = pc;
  assign npc_IF   = pc + 32'd4;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed checks of the fetch unit: sequencing, held redirects, wrap, halt and reset.
module tb_pc_fetch_unit;
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;

  pc_fetch_unit_if pif ();

  int n_chk = 0;
  int n_err = 0;

  pc_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK                  (pif.CLK),
    .nRST                 (pif.nRST),
    .enable_pc            (pif.enable_pc),
    .PCSrc                (pif.PCSrc),
    .ihit                 (pif.ihit),
    .halt                 (pif.halt),
    .branch_target_EX_MEM (pif.branch_target_EX_MEM),
    .jr_target            (pif.jr_target),
    .jaddr_IF_ID          (pif.jaddr_IF_ID),
    .npc_IF_ID            (pif.npc_IF_ID),
    .imemaddr             (pif.imemaddr),
    .imemREN              (pif.imemREN),
    .pc_IF                (pif.pc_IF),
    .npc_IF               (pif.npc_IF),
    .halted               (pif.halted)
  );

  initial begin
    pif.CLK = 1'b0;
    forever #5 pif.CLK = ~pif.CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pif.CLK);
    #1;
  endtask

  initial begin
    pif.nRST = 1'b0; pif.enable_pc = 1'b1; pif.ihit = 1'b0; pif.halt = 1'b0;
    pif.PCSrc = SEL_NPC; pif.branch_target_EX_MEM = '0; pif.jr_target = '0;
    pif.jaddr_IF_ID = '0; pif.npc_IF_ID = '0;
    step();
    chk("rst_addr", pif.imemaddr, 32'h0);
    chk("rst_pc", pif.pc_IF, 32'h0);
    chk("rst_npc", pif.npc_IF, 32'h4);
    chk("rst_ren", {31'b0, pif.imemREN}, 32'h1);
    chk("rst_halted", {31'b0, pif.halted}, 32'h0);

    // Sequential fetch
    pif.nRST = 1'b1; pif.ihit = 1'b1;
    step(); chk("seq1", pif.imemaddr, 32'h4);
    step(); chk("seq2", pif.imemaddr, 32'h8);
    step(); chk("seq3", pif.imemaddr, 32'hC);
    chk("seq3_npc", pif.npc_IF, 32'h10);

    pif.PCSrc = SEL_BRANCH; pif.branch_target_EX_MEM = 32'h100;
    step(); chk("br_direct", pif.imemaddr, 32'h100);

    // Jump held while fetch stalls
    pif.PCSrc = SEL_JUMP; pif.jaddr_IF_ID = 26'h40; pif.npc_IF_ID = 32'h104; pif.ihit = 1'b0;
    step(); chk("jpend1", pif.imemaddr, 32'h100);
    chk("jpend_ren", {31'b0, pif.imemREN}, 32'h1);
    step(); chk("jpend2", pif.imemaddr, 32'h100);
    pif.PCSrc = SEL_NPC; pif.ihit = 1'b1;
    step(); chk("jrelease", pif.imemaddr, 32'h100);
    step(); chk("jrun", pif.imemaddr, 32'h104);

    // Branch overrides a pending jump; later JR ignored
    pif.PCSrc = SEL_JUMP; pif.jaddr_IF_ID = 26'h80; pif.npc_IF_ID = 32'h108; pif.ihit = 1'b0;
    step(); chk("ovr_hold1", pif.imemaddr, 32'h104);
    pif.PCSrc = SEL_BRANCH; pif.branch_target_EX_MEM = 32'h300;
    step(); chk("ovr_hold2", pif.imemaddr, 32'h104);
    pif.PCSrc = SEL_JR; pif.jr_target = 32'h400;
    step(); chk("ovr_hold3", pif.imemaddr, 32'h104);
    pif.PCSrc = SEL_NPC; pif.ihit = 1'b1;
    step(); chk("ovr_release", pif.imemaddr, 32'h300);
    step(); chk("ovr_run", pif.imemaddr, 32'h304);

    // Branch arriving in PEND together with ihit goes straight through
    pif.PCSrc = SEL_JUMP; pif.ihit = 1'b0;
    step(); chk("bdir_hold", pif.imemaddr, 32'h304);
    pif.PCSrc = SEL_BRANCH; pif.branch_target_EX_MEM = 32'h500; pif.ihit = 1'b1;
    step(); chk("bdir_take", pif.imemaddr, 32'h500);

    // Stall without redirect; enable_pc gating
    pif.PCSrc = SEL_NPC; pif.ihit = 1'b0;
    step(); chk("stall_ihit", pif.imemaddr, 32'h500);
    pif.ihit = 1'b1; pif.enable_pc = 1'b0;
    step(); chk("stall_en", pif.imemaddr, 32'h500);
    pif.enable_pc = 1'b1;

    // Alignment and wrap
    pif.PCSrc = SEL_JR; pif.jr_target = 32'hFFFF_FFFF;
    step(); chk("jr_align", pif.imemaddr, 32'hFFFF_FFFC);
    chk("wrap_npc", pif.npc_IF, 32'h0);
    pif.PCSrc = SEL_NPC;
    step(); chk("wrap_pc", pif.imemaddr, 32'h0);
    pif.PCSrc = SEL_JR; pif.jr_target = 32'h13;
    step(); chk("jr_13", pif.imemaddr, 32'h10);

    // Halt beats a simultaneous branch
    pif.halt = 1'b1; pif.PCSrc = SEL_BRANCH; pif.branch_target_EX_MEM = 32'h700;
    step(); chk("halt_pc", pif.imemaddr, 32'h10);
    chk("halt_ren", {31'b0, pif.imemREN}, 32'h0);
    chk("halt_flag", {31'b0, pif.halted}, 32'h1);
    pif.halt = 1'b0; pif.PCSrc = SEL_NPC;
    step(); chk("halt_frozen", pif.imemaddr, 32'h10);
    chk("halt_sticky", {31'b0, pif.halted}, 32'h1);
    pif.nRST = 1'b0;
    step(); chk("unhalt_pc", pif.imemaddr, 32'h0);
    chk("unhalt_ren", {31'b0, pif.imemREN}, 32'h1);
    chk("unhalt_flag", {31'b0, pif.halted}, 32'h0);

    // Reset drops a pending redirect
    pif.nRST = 1'b1; pif.PCSrc = SEL_JUMP; pif.jaddr_IF_ID = 26'h80;
    pif.npc_IF_ID = 32'h108; pif.ihit = 1'b0;
    step(); chk("rpend_hold", pif.imemaddr, 32'h0);
    pif.nRST = 1'b0;
    step(); chk("rpend_rst", pif.imemaddr, 32'h0);
    pif.nRST = 1'b1; pif.PCSrc = SEL_NPC; pif.ihit = 1'b1;
    step(); chk("rpend_dropped", pif.imemaddr, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
